fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues in-order requests to instruction memory at pc_in, tracks the
// {pc,pc4} of each outstanding request in a 2-entry tag FIFO, and buffers
// returned words in a 2-entry instruction queue toward decode. A flush
// empties both structures and drains (discards) the responses still in flight.
// Optional feature macro: FETCH_BYPASS_EN -- a response that arrives while
// the queue is empty is presented to decode in the same cycle.
module fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [ADDR_W-1:0] pc4_in,
   output logic              pc_stall,
   input  logic              flush,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              id_valid,
   output logic [DATA_W-1:0] id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc4,
   input  logic              id_ready
);

   typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [ADDR_W-1:0] pc4;
   } tag_t;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      tag_t              tag;
   } entry_t;

   state_e      state_q, state_d;
   logic [1:0]  drop_cnt_q, drop_cnt_d;

   tag_t        tag_mem_q [2];
   tag_t        tag_mem_d [2];
   logic        tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
   logic [1:0]  tag_cnt_q, tag_cnt_d;

   entry_t      q_mem_q [2];
   entry_t      q_mem_d [2];
   logic        q_wp_q, q_wp_d, q_rp_q, q_rp_d;
   logic [1:0]  q_cnt_q, q_cnt_d;

   logic        req_acc;    // request handshake this cycle
   logic        rsp_hit;    // response that matches an outstanding tag
   logic        rsp_acc;    // response kept (not flushed, not drained)
   logic        drain_rsp;  // response discarded while draining
   logic        byp;        // response forwarded straight to decode
   logic        q_push, q_pop;
   entry_t      rsp_entry;
   entry_t      head;

   assign rsp_hit   = imem_rvalid && (tag_cnt_q != 2'd0);
   assign rsp_acc   = rsp_hit && (state_q == S_RUN) && !flush;
   assign drain_rsp = imem_rvalid && (state_q == S_DRAIN) && (drop_cnt_q != 2'd0);
   assign req_acc   = imem_req && imem_gnt;
   assign rsp_entry = '{instr: imem_rdata, tag: tag_mem_q[tag_rp_q]};

`ifdef FETCH_BYPASS_EN
   assign byp = rsp_acc && (q_cnt_q == 2'd0);
`else
   assign byp = 1'b0;
`endif

   // State register: all flops, synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q    <= S_RUN;
         drop_cnt_q <= 2'd0;
         tag_wp_q   <= 1'b0;
         tag_rp_q   <= 1'b0;
         tag_cnt_q  <= 2'd0;
         q_wp_q     <= 1'b0;
         q_rp_q     <= 1'b0;
         q_cnt_q    <= 2'd0;
         // NOTE: the storage arrays are reset too, because decode must see id_* = 0 out of reset.
         for (int i = 0; i < 2; i++) begin
            tag_mem_q[i] <= '0;
            q_mem_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         drop_cnt_q <= drop_cnt_d;
         tag_wp_q   <= tag_wp_d;
         tag_rp_q   <= tag_rp_d;
         tag_cnt_q  <= tag_cnt_d;
         q_wp_q     <= q_wp_d;
         q_rp_q     <= q_rp_d;
         q_cnt_q    <= q_cnt_d;
         tag_mem_q  <= tag_mem_d;
         q_mem_q    <= q_mem_d;
      end
   end

   // Next-state logic: RUN/DRAIN and the count of responses still to discard.
   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latch inferred.
      state_d    = state_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         S_RUN: begin
            if (flush) begin
               // A response arriving in the flush cycle is already retired.
               drop_cnt_d = tag_cnt_q - {1'b0, rsp_hit};
               if (drop_cnt_d != 2'd0) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // A flush here changes nothing: no new requests were issued.
            if (drain_rsp) begin
               drop_cnt_d = drop_cnt_q - 2'd1;
               if (drop_cnt_d == 2'd0) state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // Tag FIFO and instruction queue pointer/occupancy updates.
   always_comb begin
      tag_mem_d = tag_mem_q;
      tag_wp_d  = tag_wp_q;
      tag_rp_d  = tag_rp_q;
      tag_cnt_d = tag_cnt_q;
      q_mem_d   = q_mem_q;
      q_wp_d    = q_wp_q;
      q_rp_d    = q_rp_q;
      q_cnt_d   = q_cnt_q;
      q_push    = rsp_acc && !(byp && id_ready);
      q_pop     = (q_cnt_q != 2'd0) && id_valid && id_ready;
      if (flush) begin
         tag_wp_d  = 1'b0;
         tag_rp_d  = 1'b0;
         tag_cnt_d = 2'd0;
         q_wp_d    = 1'b0;
         q_rp_d    = 1'b0;
         q_cnt_d   = 2'd0;
      end else begin
         if (req_acc) begin
            tag_mem_d[tag_wp_q] = '{pc: pc_in, pc4: pc4_in};
            tag_wp_d            = ~tag_wp_q;
         end
         if (rsp_acc) tag_rp_d = ~tag_rp_q;
         tag_cnt_d = tag_cnt_q + {1'b0, req_acc} - {1'b0, rsp_acc};
         if (q_push) begin
            q_mem_d[q_wp_q] = rsp_entry;
            q_wp_d          = ~q_wp_q;
         end
         if (q_pop) q_rp_d = ~q_rp_q;
         q_cnt_d = q_cnt_q + {1'b0, q_push} - {1'b0, q_pop};
      end
   end

   // Outputs: request gating, PC hold and the decode handoff.
   always_comb begin
      imem_addr = pc_in;
      imem_req  = !rst && (state_q == S_RUN) && !flush &&
                  (({1'b0, tag_cnt_q} + {1'b0, q_cnt_q}) < 3'd2);
      if (rst)        pc_stall = 1'b1;
      else if (flush) pc_stall = 1'b0;
      else            pc_stall = !(imem_req && imem_gnt);
      head     = byp ? rsp_entry : q_mem_q[q_rp_q];
      id_valid = !rst && !flush && ((q_cnt_q != 2'd0) || byp);
      id_instr = head.instr;
      id_pc    = head.tag.pc;
      id_pc4   = head.tag.pc4;
   end

endmodule
